id_issue_stage: RTL and testbench
=================================

Name: id_issue_stage

Overview:
- Issue stage between decode/register-file read and execute in the simple CPU pipeline.
- Drives the register file read addresses from the decoded instruction and captures the operands.
- Keeps a 32-entry pending-write scoreboard; stalls on RAW/WAW hazards, bypasses same-cycle writeback data, and presents a registered ID/EX bundle to execute over a valid/ready handshake.
- Writeback updates the register file on the same clock edge it clears the scoreboard. Read-during-write therefore returns stale data, which this block bypasses.

Parameters:
XLEN, 64, operand/data width
CTRL_W, 16, opaque execute-control bundle width, passed through unchanged

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts the instruction this cycle
in_rs1  in  5  source register 1 (instruction[19:15])
in_rs2  in  5  source register 2 (instruction[24:20])
in_rd  in  5  destination register (instruction[11:7])
in_uses_rs1  in  1  instruction reads rs1
in_uses_rs2  in  1  instruction reads rs2
in_writes_rd  in  1  instruction writes rd
in_imm  in  XLEN  sign-extended immediate
in_ctrl  in  CTRL_W  execute control
rf_raddr1  out  5  register file read address 1, equal to in_rs1
rf_raddr2  out  5  register file read address 2, equal to in_rs2
rf_rdata1  in  XLEN  register file read data 1
rf_rdata2  in  XLEN  register file read data 2
wb_valid  in  1  writeback this cycle
wb_rd  in  5  writeback destination
wb_data  in  XLEN  writeback data
flush  in  1  kill the instruction held in the output register
out_valid  out  1  bundle valid to execute
out_ready  in  1  execute accepts the bundle
out_rs1_data  out  XLEN  operand 1
out_rs2_data  out  XLEN  operand 2
out_imm  out  XLEN  immediate
out_rd  out  5  destination register
out_writes_rd  out  1  destination write enable
out_ctrl  out  CTRL_W  control
busy_vec  out  32  scoreboard state, for debug and verification

Behaviour:
- Reset, asynchronous: busy_vec=0 and out_valid=0; all out_* data and ctrl are 0.
- x0:
  - never marked busy;
  - an operand with rs=0 yields 0 regardless of rf_rdata;
  - wb_valid with wb_rd=0 is ignored.
- wb_clr[r] = wb_valid && wb_rd==r && r!=0.
- eff_busy[r] = busy_vec[r] && !wb_clr[r].
- hazard = (in_uses_rs1 && eff_busy[rs1]) || (in_uses_rs2 && eff_busy[rs2]) || (in_writes_rd && eff_busy[rd]).
  - Covers RAW and WAW.
  - Guarantees at most one pending writer per register.
- in_ready = !flush && (!out_valid || out_ready) && !hazard. It is combinational on the in_* fields.
- accept = in_valid && in_ready.
- Operand select, per source: 0 if rs=0; else wb_data if wb_clr[rs]; else rf_rdata.
- On accept (latency 1): at the next edge out_valid=1 and all out_* fields are loaded.
- If out_valid && out_ready && !accept: out_valid goes to 0 at the next edge.
- While out_valid && !out_ready: all out_* fields are held stable.
- Scoreboard next state:
  - wb_clr[r] clears bit r;
  - accept with in_writes_rd and rd!=0 sets bit rd;
  - set takes priority over clear on the same index.
- Flush, synchronous:
  - out_valid goes to 0;
  - if out_valid && out_writes_rd && out_rd!=0, busy_vec[out_rd] is cleared;
  - no accept that cycle;
  - a concurrent writeback still clears its bit.
- Instructions already accepted by execute are unaffected by flush and must write back.
- A wb to a non-busy register only updates the register file; the scoreboard is unchanged.
- Reset mid-stall: everything returns to the reset state immediately. The pending scoreboard is lost; upstream is reset with it.

Test Plan:
- Assert reset mid-operation with busy_vec=0x00000020 and out_valid=1 -> busy_vec=0 and out_valid=0 immediately, without waiting for a clock edge.
- Two independent instructions back-to-back (x1 and x2, rs from {x3,x4}, rf_rdata=0x11/0x22) with out_ready=1 -> out_valid one cycle after each accept, operands 0x11/0x22, busy_vec=0x6.
- Issue writing x5, then an instruction reading x5 -> in_ready=0 until wb_valid, wb_rd=5, wb_data=0xDEAD. In that same cycle it is accepted with out_rs1_data=0xDEAD; busy_vec[5] ends 0, or 1 if the new instruction also writes x5.
- rs1=0 with rf_rdata1=0xFFFF, and rd=0 -> out_rs1_data=0 and busy_vec unchanged.
- out_ready=0 for 3 cycles with a held bundle and in_valid=1 -> in_ready=0 and out_* stable. When out_ready=1, the new bundle appears next cycle.
- Held bundle writing x7 with flush=1 -> out_valid=0 next cycle and busy_vec[7]=0. A concurrent wb to x9 clears busy_vec[9] as well.

Source files
------------

// File: rtl/id_issue_stage_if.sv
// rtl/id_issue_stage_if.sv - Decode, register-file, writeback, flush and ID/EX signals of the issue stage.
interface id_issue_stage_if #(
   parameter int XLEN   = 64,
   parameter int CTRL_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [4:0]        in_rd;
   logic              in_uses_rs1;
   logic              in_uses_rs2;
   logic              in_writes_rd;
   logic [XLEN-1:0]   in_imm;
   logic [CTRL_W-1:0] in_ctrl;
   logic [4:0]        rf_raddr1;
   logic [4:0]        rf_raddr2;
   logic [XLEN-1:0]   rf_rdata1;
   logic [XLEN-1:0]   rf_rdata2;
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_rs1_data;
   logic [XLEN-1:0]   out_rs2_data;
   logic [XLEN-1:0]   out_imm;
   logic [4:0]        out_rd;
   logic              out_writes_rd;
   logic [CTRL_W-1:0] out_ctrl;
   logic [31:0]       busy_vec;

   // master: the surrounding pipeline; slave: the issue stage itself
   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2, in_writes_rd,
      output in_imm, in_ctrl, rf_rdata1, rf_rdata2, wb_valid, wb_rd, wb_data, flush, out_ready,
      input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_rs1_data, out_rs2_data,
      input  out_imm, out_rd, out_writes_rd, out_ctrl, busy_vec
   );

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2, in_writes_rd,
      input  in_imm, in_ctrl, rf_rdata1, rf_rdata2, wb_valid, wb_rd, wb_data, flush, out_ready,
      output in_ready, rf_raddr1, rf_raddr2, out_valid, out_rs1_data, out_rs2_data,
      output out_imm, out_rd, out_writes_rd, out_ctrl, busy_vec
   );
endinterface

// File: rtl/id_issue_stage.sv
// rtl/id_issue_stage.sv - Issue stage: scoreboard hazard stall, writeback bypass, registered ID/EX bundle.
module id_issue_stage #(
   parameter int XLEN   = 64,
   parameter int CTRL_W = 16
) (
   input logic             clock,
   input logic             reset,
   id_issue_stage_if.slave bus
);
   logic [31:0]       busy_q;
   logic [31:0]       busy_next;
   logic [31:0]       wb_clr;
   logic [31:0]       eff_busy;
   logic              hazard;
   logic              ready;
   logic              accept;
   logic [XLEN-1:0]   op1;
   logic [XLEN-1:0]   op2;

   logic              valid_q;
   logic [XLEN-1:0]   rs1_data_q;
   logic [XLEN-1:0]   rs2_data_q;
   logic [XLEN-1:0]   imm_q;
   logic [4:0]        rd_q;
   logic              writes_q;
   logic [CTRL_W-1:0] ctrl_q;

   always_comb begin
      wb_clr = '0;
      if (bus.wb_valid && bus.wb_rd != 5'd0)
         wb_clr[bus.wb_rd] = 1'b1;
   end

   // A register retiring this cycle is already free: the register file write lands on this edge
   assign eff_busy = busy_q & ~wb_clr;

   assign hazard = (bus.in_uses_rs1  && eff_busy[bus.in_rs1]) ||
                   (bus.in_uses_rs2  && eff_busy[bus.in_rs2]) ||
                   (bus.in_writes_rd && eff_busy[bus.in_rd]);

   assign ready  = !bus.flush && (!valid_q || bus.out_ready) && !hazard;
   assign accept = bus.in_valid && ready;

   // The register file returns stale data while it is being written, so forward wb_data
   always_comb begin
      op1 = bus.rf_rdata1;
      if (bus.in_rs1 == 5'd0)
         op1 = '0;
      else if (wb_clr[bus.in_rs1])
         op1 = bus.wb_data;

      op2 = bus.rf_rdata2;
      if (bus.in_rs2 == 5'd0)
         op2 = '0;
      else if (wb_clr[bus.in_rs2])
         op2 = bus.wb_data;
   end

   // Set after clear so a new writer of a retiring register keeps its bit
   always_comb begin
      busy_next = busy_q & ~wb_clr;
      if (bus.flush && valid_q && writes_q && rd_q != 5'd0)
         busy_next[rd_q] = 1'b0;
      if (accept && bus.in_writes_rd && bus.in_rd != 5'd0)
         busy_next[bus.in_rd] = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_q     <= '0;
         valid_q    <= 1'b0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rd_q       <= '0;
         writes_q   <= 1'b0;
         ctrl_q     <= '0;
      end else begin
         busy_q <= busy_next;
         if (accept) begin
            valid_q    <= 1'b1;
            rs1_data_q <= op1;
            rs2_data_q <= op2;
            imm_q      <= bus.in_imm;
            rd_q       <= bus.in_rd;
            writes_q   <= bus.in_writes_rd;
            ctrl_q     <= bus.in_ctrl;
         end else if (bus.flush || bus.out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready      = ready;
   assign bus.rf_raddr1     = bus.in_rs1;
   assign bus.rf_raddr2     = bus.in_rs2;
   assign bus.out_valid     = valid_q;
   assign bus.out_rs1_data  = rs1_data_q;
   assign bus.out_rs2_data  = rs2_data_q;
   assign bus.out_imm       = imm_q;
   assign bus.out_rd        = rd_q;
   assign bus.out_writes_rd = writes_q;
   assign bus.out_ctrl      = ctrl_q;
   assign bus.busy_vec      = busy_q;
endmodule

// File: tb/tb_id_issue_stage.sv
// tb/tb_id_issue_stage.sv - Directed self-checking bench for id_issue_stage.
module tb_id_issue_stage;
   localparam int XLEN   = 64;
   localparam int CTRL_W = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   id_issue_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

   id_issue_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic clear_in();
      bus.in_valid     = 1'b0;
      bus.in_rs1       = 5'd0;
      bus.in_rs2       = 5'd0;
      bus.in_rd        = 5'd0;
      bus.in_uses_rs1  = 1'b0;
      bus.in_uses_rs2  = 1'b0;
      bus.in_writes_rd = 1'b0;
      bus.in_imm       = '0;
      bus.in_ctrl      = '0;
      bus.rf_rdata1    = '0;
      bus.rf_rdata2    = '0;
      bus.wb_valid     = 1'b0;
      bus.wb_rd        = 5'd0;
      bus.wb_data      = '0;
      bus.flush        = 1'b0;
   endtask

   task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic u1, input logic u2, input logic w,
                              input logic [XLEN-1:0] imm, input logic [CTRL_W-1:0] ctrl);
      bus.in_valid     = 1'b1;
      bus.in_rs1       = rs1;
      bus.in_rs2       = rs2;
      bus.in_rd        = rd;
      bus.in_uses_rs1  = u1;
      bus.in_uses_rs2  = u2;
      bus.in_writes_rd = w;
      bus.in_imm       = imm;
      bus.in_ctrl      = ctrl;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wb_once(input logic [4:0] rd);
      clear_in();
      bus.wb_valid = 1'b1;
      bus.wb_rd    = rd;
      bus.wb_data  = 64'h0;
      tick();
      bus.wb_valid = 1'b0;
   endtask

   task automatic test_reset();
      clear_in();
      bus.out_ready = 1'b1;
      #12;
      n_checks++; if (bus.busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", bus.busy_vec); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      n_checks++; if (bus.out_rs1_data !== 64'h0 || bus.out_ctrl !== 16'h0 || bus.out_rd !== 5'd0)
         begin n_fail++; $display("FAIL reset_out_fields: got rs1=%h ctrl=%h rd=%0d expected 0", bus.out_rs1_data, bus.out_ctrl, bus.out_rd); end
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      tick();
      bus.out_ready = 1'b1;
      drive_instr(5'd3, 5'd4, 5'd1, 1'b1, 1'b1, 1'b1, 64'h100, 16'h00A1);
      bus.rf_rdata1 = 64'h11;
      bus.rf_rdata2 = 64'h22;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_a: got %b expected 1", bus.in_ready); end
      n_checks++; if (bus.rf_raddr1 !== 5'd3 || bus.rf_raddr2 !== 5'd4) begin n_fail++; $display("FAIL b2b_raddr: got %0d/%0d expected 3/4", bus.rf_raddr1, bus.rf_raddr2); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rs1_data !== 64'h11 || bus.out_rs2_data !== 64'h22 || bus.out_rd !== 5'd1)
         begin n_fail++; $display("FAIL b2b_out_a: got v=%b %h/%h rd=%0d expected 1 11/22 rd=1", bus.out_valid, bus.out_rs1_data, bus.out_rs2_data, bus.out_rd); end
      n_checks++; if (bus.out_imm !== 64'h100 || bus.out_ctrl !== 16'h00A1 || bus.out_writes_rd !== 1'b1)
         begin n_fail++; $display("FAIL b2b_fields_a: got imm=%h ctrl=%h w=%b expected 100 00a1 1", bus.out_imm, bus.out_ctrl, bus.out_writes_rd); end
      n_checks++; if (bus.busy_vec !== 32'h2) begin n_fail++; $display("FAIL b2b_busy_a: got %h expected 2", bus.busy_vec); end
      drive_instr(5'd3, 5'd4, 5'd2, 1'b1, 1'b1, 1'b1, 64'h200, 16'h00B2);
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_b: got %b expected 1", bus.in_ready); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd2 || bus.out_rs1_data !== 64'h11 || bus.out_rs2_data !== 64'h22)
         begin n_fail++; $display("FAIL b2b_out_b: got v=%b rd=%0d %h/%h expected 1 rd=2 11/22", bus.out_valid, bus.out_rd, bus.out_rs1_data, bus.out_rs2_data); end
      n_checks++; if (bus.busy_vec !== 32'h6) begin n_fail++; $display("FAIL b2b_busy_b: got %h expected 6", bus.busy_vec); end
      clear_in();
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", bus.out_valid); end
      wb_once(5'd10);
      n_checks++; if (bus.busy_vec !== 32'h6) begin n_fail++; $display("FAIL wb_nonbusy: got %h expected 6", bus.busy_vec); end
      wb_once(5'd1);
      wb_once(5'd2);
      n_checks++; if (bus.busy_vec !== 32'h0) begin n_fail++; $display("FAIL b2b_retire: got %h expected 0", bus.busy_vec); end
   endtask

   task automatic test_raw_bypass();
      drive_instr(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 64'h0, 16'h0);
      tick();
      n_checks++; if (bus.busy_vec !== 32'h20) begin n_fail++; $display("FAIL raw_busy_set: got %h expected 20", bus.busy_vec); end
      drive_instr(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 64'h0, 16'h0);
      bus.rf_rdata1 = 64'h5555;
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall: got %b expected 0", bus.in_ready); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b0 || bus.busy_vec !== 32'h20)
         begin n_fail++; $display("FAIL raw_stall_state: got v=%b busy=%h expected 0 20", bus.out_valid, bus.busy_vec); end
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd5;
      bus.wb_data  = 64'hDEAD;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b expected 1", bus.in_ready); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rs1_data !== 64'hDEAD || bus.out_rd !== 5'd6)
         begin n_fail++; $display("FAIL raw_bypass: got v=%b rs1=%h rd=%0d expected 1 dead 6", bus.out_valid, bus.out_rs1_data, bus.out_rd); end
      n_checks++; if (bus.busy_vec !== 32'h40) begin n_fail++; $display("FAIL raw_busy_end: got %h expected 40", bus.busy_vec); end
      wb_once(5'd6);
      drive_instr(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 64'h0, 16'h0);
      tick();
      drive_instr(5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 64'h0, 16'h0);
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall: got %b expected 0", bus.in_ready); end
      bus.in_uses_rs1 = 1'b1;
      bus.wb_valid    = 1'b1;
      bus.wb_rd       = 5'd5;
      bus.wb_data     = 64'hBEEF;
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rs1_data !== 64'hBEEF || bus.busy_vec !== 32'h20)
         begin n_fail++; $display("FAIL waw_set_wins: got v=%b rs1=%h busy=%h expected 1 beef 20", bus.out_valid, bus.out_rs1_data, bus.busy_vec); end
      wb_once(5'd5);
      n_checks++; if (bus.busy_vec !== 32'h0) begin n_fail++; $display("FAIL raw_retire: got %h expected 0", bus.busy_vec); end
   endtask

   task automatic test_x0();
      drive_instr(5'd0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 64'h0, 16'h0);
      bus.rf_rdata1 = 64'hFFFF;
      bus.rf_rdata2 = 64'h2222;
      bus.wb_valid  = 1'b1;
      bus.wb_rd     = 5'd0;
      bus.wb_data   = 64'h1234;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b expected 1", bus.in_ready); end
      tick();
      n_checks++; if (bus.out_rs1_data !== 64'h0 || bus.out_rs2_data !== 64'h2222)
         begin n_fail++; $display("FAIL x0_operand: got %h/%h expected 0/2222", bus.out_rs1_data, bus.out_rs2_data); end
      n_checks++; if (bus.busy_vec !== 32'h0) begin n_fail++; $display("FAIL x0_busy: got %h expected 0", bus.busy_vec); end
      clear_in();
      tick();
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      drive_instr(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 64'h77, 16'h0007);
      tick();
      drive_instr(5'd3, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 64'h88, 16'h0008);
      bus.rf_rdata1 = 64'h33;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_%0d: got %b expected 0", i, bus.in_ready); end
         n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd7 || bus.out_imm !== 64'h77 || bus.out_ctrl !== 16'h0007)
            begin n_fail++; $display("FAIL bp_hold_%0d: got v=%b rd=%0d imm=%h ctrl=%h expected 1 7 77 0007", i, bus.out_valid, bus.out_rd, bus.out_imm, bus.out_ctrl); end
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b expected 1", bus.in_ready); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd8 || bus.out_rs1_data !== 64'h33 || bus.out_imm !== 64'h88)
         begin n_fail++; $display("FAIL bp_next: got v=%b rd=%0d rs1=%h imm=%h expected 1 8 33 88", bus.out_valid, bus.out_rd, bus.out_rs1_data, bus.out_imm); end
      n_checks++; if (bus.busy_vec !== 32'h180) begin n_fail++; $display("FAIL bp_busy: got %h expected 180", bus.busy_vec); end
      clear_in();
      tick();
      wb_once(5'd7);
      wb_once(5'd8);
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b1;
      drive_instr(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 64'h0, 16'h0);
      tick();
      drive_instr(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 64'h0, 16'h0);
      tick();
      n_checks++; if (bus.busy_vec !== 32'h280 || bus.out_rd !== 5'd7)
         begin n_fail++; $display("FAIL flush_setup: got busy=%h rd=%0d expected 280 7", bus.busy_vec, bus.out_rd); end
      clear_in();
      bus.out_ready = 1'b0;
      tick();
      drive_instr(5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1, 64'h0, 16'h0);
      bus.flush    = 1'b1;
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd9;
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %b expected 0", bus.in_ready); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", bus.out_valid); end
      n_checks++; if (bus.busy_vec !== 32'h0) begin n_fail++; $display("FAIL flush_busy: got %h expected 0", bus.busy_vec); end
      clear_in();
      bus.out_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0;
      drive_instr(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 64'h55, 16'h0055);
      tick();
      clear_in();
      n_checks++; if (bus.busy_vec !== 32'h20 || bus.out_valid !== 1'b1)
         begin n_fail++; $display("FAIL rmid_setup: got busy=%h v=%b expected 20 1", bus.busy_vec, bus.out_valid); end
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (bus.busy_vec !== 32'h0 || bus.out_valid !== 1'b0)
         begin n_fail++; $display("FAIL rmid_async: got busy=%h v=%b expected 0 0", bus.busy_vec, bus.out_valid); end
      n_checks++; if (bus.out_imm !== 64'h0 || bus.out_rd !== 5'd0 || bus.out_writes_rd !== 1'b0)
         begin n_fail++; $display("FAIL rmid_fields: got imm=%h rd=%0d w=%b expected 0", bus.out_imm, bus.out_rd, bus.out_writes_rd); end
      #2;
      reset = 1'b0;
      tick();
      n_checks++; if (bus.busy_vec !== 32'h0 || bus.out_valid !== 1'b0)
         begin n_fail++; $display("FAIL rmid_after: got busy=%h v=%b expected 0 0", bus.busy_vec, bus.out_valid); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_raw_bypass();
      test_x0();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
